dmem_line_responder: RTL and testbench
======================================

# dmem_line_responder

Responder side of the CPU data-memory interface: accepts the byte-masked word requests (address, read mask, write mask, lane-aligned write data) issued by the memory stage and answers them with read data and a one-cycle response strobe. Holds a single 256-bit line buffer (one valid/dirty/tag entry) in front of a line-granular physical memory port, writing back dirty lines and fetching missing ones. It sits between the pipeline memory stage and the physical memory arbiter.

## Interface
- Parameters: none (line size fixed at 256 bits / 32 bytes, word select addr[4:2], tag addr[31:5]).
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dmem_addr  in  32  byte address of request; bits [1:0] ignored
- dmem_rmask  in  4  read byte mask; nonzero = read request
- dmem_wmask  in  4  write byte mask; nonzero = write request
- dmem_wdata  in  32  write data, already shifted to byte lanes
- dmem_rdata  out  32  full addressed word (unshifted), valid when dmem_resp=1
- dmem_resp  out  1  one-cycle completion strobe
- pmem_address  out  32  line address, bits [4:0]=0
- pmem_read  out  1  line read request, held until pmem_resp
- pmem_write  out  1  line write request, held until pmem_resp
- pmem_wdata  out  256  line being written back
- pmem_rdata  in  256  fetched line, valid when pmem_resp=1
- pmem_resp  in  1  physical memory completion strobe

## Operation
- Request present when (dmem_rmask | dmem_wmask) != 0. Requester holds addr/masks/wdata stable until dmem_resp; the cycle after dmem_resp it must change or drop the request.
- Both masks nonzero: write performed, dmem_rdata returns the post-write word.
- Hit: line_valid && line_tag == dmem_addr[31:5].
- State machine: IDLE, RESP, WRITEBACK, FETCH.
- IDLE, no request: stay.
- IDLE, hit: at the edge, dmem_rdata register <= merged word of line[addr[4:2]]; for each i with wmask[i], byte i of that word <= wdata byte i; dirty <= 1 if wmask != 0; -> RESP.
- IDLE, miss, valid && dirty: -> WRITEBACK. Miss, otherwise: -> FETCH.
- RESP: dmem_resp=1 for exactly this cycle; -> IDLE.
- WRITEBACK: pmem_write=1, pmem_address={line_tag,5'b0}, pmem_wdata=line; on pmem_resp: dirty <= 0, -> FETCH.
- FETCH: pmem_read=1, pmem_address={dmem_addr[31:5],5'b0}; on pmem_resp: line <= pmem_rdata, tag <= dmem_addr[31:5], valid <= 1, dirty <= 0, -> IDLE (request then hits).
- pmem_read and pmem_write never both high. pmem_address/pmem_wdata are 0 outside WRITEBACK/FETCH.
- Byte i of the word maps to line bits [addr[4:2]*32 + 8i +: 8].

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, line_valid=0, line_dirty=0, dmem_resp=0, dmem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. Line data and tag contents are don't-care.
- Reset mid-WRITEBACK or mid-FETCH: pmem strobes drop immediately; dirty data is discarded.
- Hit latency: request seen in IDLE at cycle 0 -> dmem_resp at cycle 1 -> IDLE at cycle 2.
- Clean miss: FETCH from cycle 1; pmem_resp sampled at cycle k -> IDLE at k+1 -> dmem_resp at k+2.
- Dirty miss: WRITEBACK from cycle 1 until pmem_resp at cycle j; FETCH from j+1 until pmem_resp at k; dmem_resp at k+2.
- pmem_resp ignored in IDLE/RESP. dmem_rdata holds its value between responses.

## Test plan
- Reset then read 0x100 (rmask=1111): one FETCH with pmem_address=0x100; pmem_rdata word 0 = 0xDEADBEEF, pmem_resp after 3 cycles -> dmem_rdata=0xDEADBEEF, dmem_resp exactly 1 cycle, at k+2.
- Hit write to 0x104, wmask=0100, wdata=0x00AB0000, then read 0x104 -> second response 1 cycle after request with byte 2 = 0xAB and other bytes unchanged; no pmem activity.
- Read 0x200 after the dirty write: WRITEBACK to 0x100 with pmem_wdata word 1 carrying 0xAB, then FETCH of 0x200; pmem_read/pmem_write never overlap.
- Clean miss on 0x300 after the line at 0x200 is unmodified -> no WRITEBACK, FETCH only.
- Both rmask=1111 and wmask=0001, wdata=0x55 on a hit -> dmem_rdata byte 0 = 0x55, line dirty.
- Assert rst_n low during FETCH with pmem_resp pending -> pmem_read=0 immediately; next read of the same address re-fetches.

Source files
------------

// File: rtl/dmem_line_responder.sv
// Single-line buffer between the pipeline data-memory port and a line-granular physical memory.
// Hits answer in one cycle; misses write back a dirty line, fetch the new one, then retry as a hit.
module dmem_line_responder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  dmem_addr,
  input  logic [3:0]   dmem_rmask,
  input  logic [3:0]   dmem_wmask,
  input  logic [31:0]  dmem_wdata,
  output logic [31:0]  dmem_rdata,
  output logic         dmem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {StIdle, StResp, StWriteback, StFetch} state_e;

  state_e       state;
  logic [255:0] line;
  logic [26:0]  line_tag;
  logic         line_valid;
  logic         line_dirty;

  logic         req;
  logic         hit;
  logic [26:0]  req_tag;
  logic [7:0]   word_lsb;
  logic [31:0]  cur_word;
  logic [31:0]  merged_word;

  always_comb begin
    req      = |(dmem_rmask | dmem_wmask);
    req_tag  = dmem_addr[31:5];
    hit      = line_valid && (line_tag == req_tag);
    word_lsb = {dmem_addr[4:2], 5'b0};
    cur_word = line[word_lsb +: 32];
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = dmem_wmask[i] ? dmem_wdata[8*i +: 8] : cur_word[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      line         <= '0;
      line_tag     <= '0;
      line_valid   <= 1'b0;
      line_dirty   <= 1'b0;
      dmem_rdata   <= '0;
      dmem_resp    <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req) begin
            if (hit) begin
              // Unwritten bytes merge back unchanged, so the store is harmless on pure reads.
              line[word_lsb +: 32] <= merged_word;
              dmem_rdata           <= merged_word;
              dmem_resp            <= 1'b1;
              if (|dmem_wmask) line_dirty <= 1'b1;
              state <= StResp;
            end else if (line_valid && line_dirty) begin
              pmem_write   <= 1'b1;
              pmem_address <= {line_tag, 5'b0};
              pmem_wdata   <= line;
              state        <= StWriteback;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, 5'b0};
              state        <= StFetch;
            end
          end
        end
        StResp: begin
          dmem_resp <= 1'b0;
          state     <= StIdle;
        end
        StWriteback: begin
          if (pmem_resp) begin
            line_dirty   <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, 5'b0};
            state        <= StFetch;
          end
        end
        StFetch: begin
          if (pmem_resp) begin
            line         <= pmem_rdata;
            line_tag     <= req_tag;
            line_valid   <= 1'b1;
            line_dirty   <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder with a 3-cycle physical memory model driven from the tasks.
module tb_dmem_line_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_rmask;
  logic [3:0]   dmem_wmask;
  logic [31:0]  dmem_wdata;
  logic [31:0]  dmem_rdata;
  logic         dmem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] mem [logic [31:0]];

  // Results of the last run_req call.
  logic [31:0]  r_rdata;
  int           r_cycles;
  int           r_nwb;
  int           r_nfetch;
  logic [31:0]  r_wb_addr;
  logic [255:0] r_wb_data;
  logic [31:0]  r_fetch_addr;
  logic         r_resp_after;
  logic         r_overlap;

  dmem_line_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = {16'hC0DE, a[15:8], 5'd0, w[2:0]};
    return l;
  endfunction

  // Drives one request, plays physical memory (resp on 3rd busy cycle), returns after dmem_resp.
  task automatic run_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
    int busy;
    r_cycles = 0; r_nwb = 0; r_nfetch = 0; r_overlap = 1'b0; busy = 0;
    r_wb_addr = '0; r_wb_data = '0; r_fetch_addr = '0; r_rdata = 'x;
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    while (1) begin
      @(negedge clk);
      r_cycles++;
      if (pmem_read && pmem_write) r_overlap = 1'b1;
      if (pmem_resp) begin pmem_resp = 1'b0; busy = 0; end
      if (dmem_resp) begin
        r_rdata = dmem_rdata;
        break;
      end
      if (r_cycles > 100) begin
        n_vec++; n_err++;
        $display("FAIL timeout addr=%h: no dmem_resp within 100 cycles", a);
        break;
      end
      if (pmem_read || pmem_write) begin
        busy++;
        if (busy == 3) begin
          if (pmem_write) begin
            r_nwb++; r_wb_addr = pmem_address; r_wb_data = pmem_wdata;
            mem[pmem_address] = pmem_wdata;
          end else begin
            r_nfetch++; r_fetch_addr = pmem_address;
            pmem_rdata = line_of(pmem_address);
          end
          pmem_resp = 1'b1;
        end
      end
    end
    dmem_rmask = '0; dmem_wmask = '0;
    @(negedge clk);
    r_resp_after = dmem_resp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dmem_resp, pmem_read, pmem_write} !== 3'b000) begin
      n_err++; $display("FAIL reset_strobes got=%b want=000", {dmem_resp, pmem_read, pmem_write});
    end
    n_vec++;
    if (dmem_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata got=%h want=0", dmem_rdata);
    end
    n_vec++;
    if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
      n_err++; $display("FAIL reset_pmem got addr=%h wdata=%h want 0", pmem_address, pmem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_fetch();
    run_req(32'h100, 4'hF, 4'h0, 32'h0);
    n_vec++;
    if (r_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL fetch_rdata got=%h want=deadbeef", r_rdata);
    end
    n_vec++;
    if (r_nfetch !== 1 || r_fetch_addr !== 32'h100 || r_nwb !== 0) begin
      n_err++; $display("FAIL fetch_pmem got fetch=%0d@%h wb=%0d want 1@100 wb=0",
                        r_nfetch, r_fetch_addr, r_nwb);
    end
    n_vec++;
    if (r_cycles !== 5) begin
      n_err++; $display("FAIL fetch_latency got=%0d want=5", r_cycles);
    end
    n_vec++;
    if (r_resp_after !== 1'b0) begin
      n_err++; $display("FAIL fetch_resp_width got=%b want=0", r_resp_after);
    end
  endtask

  task automatic test_hit_write();
    run_req(32'h104, 4'h0, 4'b0100, 32'h00AB0000);
    n_vec++;
    if (r_rdata !== 32'h11AB3344 || r_cycles !== 1) begin
      n_err++; $display("FAIL hit_write got=%h/%0d want=11ab3344/1", r_rdata, r_cycles);
    end
    run_req(32'h104, 4'hF, 4'h0, 32'h0);
    n_vec++;
    if (r_rdata !== 32'h11AB3344 || r_cycles !== 1) begin
      n_err++; $display("FAIL hit_read got=%h/%0d want=11ab3344/1", r_rdata, r_cycles);
    end
    n_vec++;
    if (r_nwb !== 0 || r_nfetch !== 0 || r_resp_after !== 1'b0) begin
      n_err++; $display("FAIL hit_no_pmem got wb=%0d fetch=%0d resp=%b want 0 0 0",
                        r_nwb, r_nfetch, r_resp_after);
    end
  endtask

  task automatic test_dirty_miss();
    run_req(32'h200, 4'hF, 4'h0, 32'h0);
    n_vec++;
    if (r_nwb !== 1 || r_wb_addr !== 32'h100) begin
      n_err++; $display("FAIL wb_addr got=%0d@%h want=1@100", r_nwb, r_wb_addr);
    end
    n_vec++;
    if (r_wb_data[63:0] !== 64'h11AB3344_DEADBEEF) begin
      n_err++; $display("FAIL wb_data got=%h want=11ab3344deadbeef", r_wb_data[63:0]);
    end
    n_vec++;
    if (r_nfetch !== 1 || r_fetch_addr !== 32'h200 || r_rdata !== 32'hC0DE0200) begin
      n_err++; $display("FAIL wb_refetch got=%0d@%h rdata=%h want=1@200 c0de0200",
                        r_nfetch, r_fetch_addr, r_rdata);
    end
    n_vec++;
    if (r_cycles !== 8 || r_overlap !== 1'b0) begin
      n_err++; $display("FAIL wb_timing got cycles=%0d overlap=%b want 8 0", r_cycles, r_overlap);
    end
  endtask

  task automatic test_clean_miss();
    run_req(32'h30C, 4'hF, 4'h0, 32'h0);
    n_vec++;
    if (r_nwb !== 0 || r_nfetch !== 1 || r_cycles !== 5) begin
      n_err++; $display("FAIL clean_miss got wb=%0d fetch=%0d cycles=%0d want 0 1 5",
                        r_nwb, r_nfetch, r_cycles);
    end
    n_vec++;
    if (r_rdata !== 32'hC0DE0303) begin
      n_err++; $display("FAIL clean_miss_rdata got=%h want=c0de0303", r_rdata);
    end
  endtask

  task automatic test_read_write();
    run_req(32'h304, 4'hF, 4'b0001, 32'h00000055);
    n_vec++;
    if (r_rdata !== 32'hC0DE0355 || r_cycles !== 1) begin
      n_err++; $display("FAIL rw_rdata got=%h/%0d want=c0de0355/1", r_rdata, r_cycles);
    end
    // Evicting the line exposes whether the combined access marked it dirty.
    run_req(32'h400, 4'hF, 4'h0, 32'h0);
    n_vec++;
    if (r_nwb !== 1 || r_wb_addr !== 32'h300 || r_wb_data[63:32] !== 32'hC0DE0355) begin
      n_err++; $display("FAIL rw_dirty got wb=%0d@%h word1=%h want 1@300 c0de0355",
                        r_nwb, r_wb_addr, r_wb_data[63:32]);
    end
  endtask

  task automatic test_reset_mid_fetch();
    dmem_addr = 32'h500; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (pmem_read !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre got pmem_read=%b want=1", pmem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      n_err++; $display("FAIL midrst_drop got read=%b addr=%h want 0 0", pmem_read, pmem_address);
    end
    dmem_rmask = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(32'h500, 4'hF, 4'h0, 32'h0);
    n_vec++;
    if (r_nfetch !== 1 || r_fetch_addr !== 32'h500 || r_rdata !== 32'hC0DE0500) begin
      n_err++; $display("FAIL midrst_refetch got=%0d@%h rdata=%h want=1@500 c0de0500",
                        r_nfetch, r_fetch_addr, r_rdata);
    end
  endtask

  initial begin
    logic [255:0] l100;
    l100 = line_of(32'h100);
    l100[31:0]  = 32'hDEADBEEF;
    l100[63:32] = 32'h11223344;
    mem[32'h100] = l100;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    test_reset();
    test_clean_fetch();
    test_hit_write();
    test_dirty_miss();
    test_clean_miss();
    test_read_write();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
